// File: rtl/reg_decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a self-sweeping scan mode.
// Latency: 1 cycle from an accepted select or scan_start to out_onehot/out_valid.
// Backpressure: in_ready drops while a sweep runs or a scan_start is pending.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready/in_sel  direct-mode select handshake
//   scan_start, scan_abort  begin a sweep (from IDLE) / terminate it (in SCAN)
//   scan_busy, scan_done    sweep in progress / one-cycle pulse at sweep end
//   out_valid, out_sel      one-cycle pulse on each new code / current binary code
//   out_onehot              decoded output, bit out_sel set
// Build option: define DECODER_ACTIVE_LOW_EN for a one-cold out_onehot (reset
// value all ones); timing and every other output are unchanged.
module reg_decoder_scan #(
    parameter int SEL_W = 4,
    parameter int DWELL = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  scan_start,
    input  logic                  scan_abort,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      out_sel,
    output logic [(2**SEL_W)-1:0] out_onehot
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam int CNT_W = $clog2(DWELL) + 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(OUT_W - 1);

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] ONEHOT_RST = '1;
`else
    localparam logic [OUT_W-1:0] ONEHOT_RST = '0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] dwell_cnt;

    // The decoded pattern is built from the binary code rather than shifting
    // the previous pattern, so the one-cold build needs no special shift fill.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // scan_start takes priority over a coincident direct request, so ready
    // is withheld in that cycle and the request stays with the producer.
    assign in_ready = (state == IDLE) && !scan_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dwell_cnt  <= '0;
            out_sel    <= '0;
            out_onehot <= ONEHOT_RST;
            out_valid  <= 1'b0;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        state      <= SCAN;
                        dwell_cnt  <= '0;
                        out_sel    <= '0;
                        out_onehot <= decode('0);
                        out_valid  <= 1'b1;
                        scan_busy  <= 1'b1;
                    end else if (in_valid) begin
                        out_sel    <= in_sel;
                        out_onehot <= decode(in_sel);
                        out_valid  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_abort) begin
                        // Abort beats a step or finish landing in the same cycle;
                        // the current code stays on the output.
                        state     <= IDLE;
                        dwell_cnt <= '0;
                        scan_busy <= 1'b0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (out_sel != SEL_LAST) begin
                            out_sel    <= out_sel + SEL_W'(1);
                            out_onehot <= decode(out_sel + SEL_W'(1));
                            out_valid  <= 1'b1;
                        end else begin
                            // Last code keeps driving after the sweep; no wrap.
                            state     <= IDLE;
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_decoder_scan.sv
module tb_reg_decoder_scan;

    localparam int SEL_W = 4;
    localparam int DWELL = 15;
    localparam int OUT_W = 16;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] RST_OH = 16'hFFFF;
`else
    localparam logic [OUT_W-1:0] RST_OH = 16'h0000;
`endif

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             in_valid   = 1'b0;
    logic [SEL_W-1:0] in_sel     = '0;
    logic             scan_start = 1'b0;
    logic             scan_abort = 1'b0;
    logic             in_ready;
    logic             scan_busy;
    logic             scan_done;
    logic             out_valid;
    logic [SEL_W-1:0] out_sel;
    logic [OUT_W-1:0] out_onehot;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;

    logic [SEL_W-1:0] sb_q[$];
    logic [SEL_W-1:0] sb_exp;

    reg_decoder_scan #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .scan_start (scan_start),
        .scan_abort (scan_abort),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .out_onehot (out_onehot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] oh(input int s);
        logic [OUT_W-1:0] v;
        v = 16'h0001 << s;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every out_valid pulse must match the next queued code.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (scan_done) n_done++;
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_valid", out_valid, 0);
                end else begin
                    sb_exp = sb_q.pop_front();
                    chk("sb_sel", out_sel, sb_exp);
                    chk("sb_onehot", out_onehot, oh(sb_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_at;
        int pulses;
        logic done_seen;

        // Reset state
        #12;
        chk("rst_onehot", out_onehot, RST_OH);
        chk("rst_sel", out_sel, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_done", scan_done, 0);
        #6 rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", in_ready, 1);

        // Direct decode: 5, then 15
        in_sel = 4'd5; in_valid = 1'b1; sb_q.push_back(4'd5);
        tick();
        in_valid = 1'b0;
        chk("dir5_onehot", out_onehot, 16'h0020 ^ (RST_OH & 16'hFFFF));
        chk("dir5_sel", out_sel, 5);
        chk("dir5_valid", out_valid, 1);
        tick();
        chk("dir5_valid_drop", out_valid, 0);
        chk("dir5_hold", out_onehot, oh(5));
        in_sel = 4'd15; in_valid = 1'b1; sb_q.push_back(4'd15);
        tick();
        in_valid = 1'b0;
        chk("dir15_onehot", out_onehot, 16'h8000 ^ (RST_OH & 16'hFFFF));

        // Back-to-back direct requests, starting with code 0
        for (int i = 0; i < 6; i++) begin
            in_sel = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            in_valid = 1'b1;
            sb_q.push_back(in_sel);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Full sweep; mid-sweep direct request and scan_start must be ignored
        scan_start = 1'b1;
        for (int k = 0; k < OUT_W; k++) sb_q.push_back(4'(k));
        tick();
        scan_start = 1'b0;
        done_at = 0;
        pulses  = 0;
        for (int c = 1; c <= 400 && done_at == 0; c++) begin
            if (out_valid) pulses++;
            if (c == 1)   chk("scan_t1", out_onehot, oh(0));
            if (c == 2)   chk("scan_busy", scan_busy, 1);
            if (c == 16)  chk("scan_t16", out_onehot, oh(1));
            if (c == 225) chk("scan_t225_sel", out_sel, 14);
            if (c == 226) chk("scan_t226", out_onehot, oh(15));
            if (c == 100) begin
                chk("scan_rdy_low", in_ready, 0);
                in_valid = 1'b1; in_sel = 4'd3; scan_start = 1'b1;
            end
            if (c == 101) begin
                in_valid = 1'b0; scan_start = 1'b0;
            end
            if (scan_done) begin
                done_at = c;
                chk("done_rdy", in_ready, 1);
                chk("done_busy", scan_busy, 0);
            end else begin
                tick();
            end
        end
        chk("done_cycle", done_at, 241);
        chk("scan_pulses", pulses, 16);
        tick();
        chk("done_one_cycle", scan_done, 0);
        chk("scan_no_wrap", out_onehot, oh(15));

        // Collision: scan wins, direct request not consumed; then abort at 7
        // timed so it coincides with the step to code 8.
        scan_start = 1'b1; in_valid = 1'b1; in_sel = 4'd9;
        #1;
        chk("coll_rdy", in_ready, 0);
        for (int k = 0; k <= 7; k++) sb_q.push_back(4'(k));
        tick();
        scan_start = 1'b0; in_valid = 1'b0;
        chk("coll_onehot", out_onehot, oh(0));
        for (int c = 0; c < 200 && out_sel != 4'd7; c++) tick();
        chk("abort_reach7", out_sel, 7);
        repeat (DWELL - 1) tick();
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;
        chk("abort_busy", scan_busy, 0);
        chk("abort_sel", out_sel, 7);
        chk("abort_onehot", out_onehot, 16'h0080 ^ (RST_OH & 16'hFFFF));
        chk("abort_valid", out_valid, 0);
        chk("abort_rdy", in_ready, 1);
        done_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            done_seen = done_seen | scan_done;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_hold", out_onehot, oh(7));

        // Asynchronous reset in the middle of a sweep
        scan_start = 1'b1;
        for (int k = 0; k <= 3; k++) sb_q.push_back(4'(k));
        tick();
        scan_start = 1'b0;
        for (int c = 0; c < 100 && out_sel != 4'd3; c++) tick();
        chk("ar_reach3", out_sel, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_onehot", out_onehot, RST_OH);
        chk("ar_sel", out_sel, 0);
        chk("ar_busy", scan_busy, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            done_seen = done_seen | scan_done;
            tick();
        end
        chk("ar_no_done", done_seen, 0);
        chk("ar_rdy", in_ready, 1);
        in_sel = 4'd7; in_valid = 1'b1; sb_q.push_back(4'd7);
        tick();
        in_valid = 1'b0;
        chk("ar_direct", out_onehot, oh(7));
        tick();

        chk("sb_drain", sb_q.size(), 0);
        chk("total_done", n_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
